dynamic_postsub_div: RTL
========================

# dynamic_postsub_div

Iterative signed divider that inverts the post-adder/multiplier datapath: given a product word P, an addend C and a multiplier B, it computes Q = (P ∓ C) / B and the remainder R. It sits downstream of the DSP multiply-add blocks in calibration and normalisation paths, where a prior (A±D)×B+C result must be un-scaled. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with valid/ready handshakes on both sides.

## Interface
- BW, 18, divisor (B) width, signed
- CW, 32, addend (C) width, signed
- PW, 48, dividend source (P) width, signed; PW > CW required
- DW, PW + 1, dividend/quotient width (derived; do not override)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- subadd  in  1  1: D = P − C; 0: D = P + C
- pin  in  PW  signed P
- cin  in  CW  signed C, sign-extended to DW
- bin  in  BW  signed divisor B
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands
- qout  out  DW  signed quotient
- rout  out  BW  signed remainder
- div0  out  1  divide-by-zero flag for current result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result

## Operation
- States: IDLE, PREP, CALC, DONE. Reset → IDLE.
- IDLE: in_ready = 1. On in_valid & in_ready: latch subadd, pin, cin, bin; go PREP.
- PREP (1 cycle): D = sext(pin) ± sext(cin) in DW bits (never overflows). Record sign_q = sign(D) XOR sign(B), sign_r = sign(D), zero flag = (B == 0). Load |D| into the shift register, |B| (BW+1 bits, so −2^(BW−1) is handled) into the divisor register, partial remainder = 0, counter = 0. Go CALC.
- CALC (DW cycles): shift {rem, dividend} left 1; if rem ≥ |B|, subtract and set quotient LSB 1, else 0. Counter increments; at counter = DW−1 go DONE.
- DONE: out_valid = 1. qout = sign_q ? −|Q| : |Q|; rout = sign_r ? −|R| : |R|. Quotient truncates toward zero; remainder takes dividend's sign (C semantics): D = Q×B + R, |R| < |B|.
- B = 0: full latency still taken; result forced to qout = 0, rout = 0, div0 = 1. Otherwise div0 = 0.
- DONE holds qout/rout/div0 stable while out_ready = 0. On out_valid & out_ready: go IDLE.
- No overflow possible: |Q| ≤ |D| < 2^(DW−1); |R| ≤ 2^(BW−1) − 1.

## Timing
- Reset values: in_ready = 0 during reset cycle, 1 in first cycle after; out_valid = 0, qout = 0, rout = 0, div0 = 0.
- Acceptance at edge k → out_valid high after edge k + DW + 1 (50 cycles for defaults).
- in_ready = 1 only in IDLE; operands presented in other states are ignored (not queued).
- Output handshake at edge m → in_ready = 1 after edge m; earliest next acceptance edge m+1. Min spacing between accepts: DW + 3 cycles.
- out_valid never drops without out_ready; outputs change only on entering DONE or reset.
- rst asserted in any state: next cycle IDLE, all outputs at reset values, in-flight result discarded.
- rst and in_valid together: reset wins, operands not accepted.

## Test plan
- pin=1000, cin=10, subadd=1, bin=7 → qout=141, rout=3, div0=0; out_valid exactly 50 cycles after accept.
- pin=−1000, cin=10, subadd=1, bin=7 → D=−1010, qout=−144, rout=−2; bin=−7 with pin=1000,cin=10,subadd=1 → qout=−141, rout=3.
- pin=2^47−1, cin=−2^31, subadd=1, bin=1 → qout=2^47+2^31−1, rout=0; pin=−2^47, cin=0, subadd=0, bin=−131072 → qout=2^30, rout=0.
- bin=0, any pin/cin → qout=0, rout=0, div0=1 after same 50-cycle latency.
- out_ready held low 20 cycles in DONE → outputs stable, in_ready=0, second in_valid ignored; release → in_ready returns next cycle, next operand accepted and correct.
- rst pulsed in CALC at iteration 20 → out_valid never asserts for that operand; next operand (pin=100, cin=0, subadd=0, bin=3) → qout=33, rout=1.

Source files
------------

// File: rtl/dynamic_postsub_div.sv
// dynamic_postsub_div
// Iterative signed divider computing Q = (P -/+ C) / B and R = (P -/+ C) % B.
// The divider is radix-2 restoring and produces one quotient bit per cycle.
// The quotient truncates toward zero and the remainder takes the dividend's sign.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   subadd        1: D = P - C, 0: D = P + C
//   pin, cin      signed P (PW bits) and signed C (CW bits)
//   bin           signed divisor B (BW bits)
//   in_valid      operand handshake; the block accepts only in IDLE
//   in_ready      operand handshake; high only in IDLE
//   qout          signed quotient (DW bits)
//   rout          signed remainder (BW bits)
//   div0          set when B was zero for the current result
//   out_valid     result handshake
//   out_ready     result handshake
module dynamic_postsub_div #(
    parameter int BW = 18,
    parameter int CW = 32,
    parameter int PW = 48,
    parameter int DW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          subadd,
    input  logic [PW-1:0] pin,
    input  logic [CW-1:0] cin,
    input  logic [BW-1:0] bin,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] qout,
    output logic [BW-1:0] rout,
    output logic          div0,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int CNTW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

    state_t          state;
    logic            sub_r;
    logic [PW-1:0]   p_r;
    logic [CW-1:0]   c_r;
    logic [BW-1:0]   b_r;
    logic [DW-1:0]   dvd;      // |D| shifting out, quotient bits shifting in
    logic [BW:0]     div_r;    // |B| with one extra bit so -2^(BW-1) fits
    logic [BW-1:0]   rem;      // partial remainder, always < |B|
    logic [CNTW-1:0] cnt;
    logic            sign_q, sign_r, zero_b;

    logic [DW-1:0]   p_ext, c_ext, d_full, d_abs;
    logic [BW:0]     b_ext, b_abs;
    logic [BW:0]     shifted;
    logic            ge;
    logic [BW-1:0]   rem_nxt;
    logic [DW-1:0]   dvd_nxt;

    // The dividend is one bit wider than P, so P +/- C cannot overflow.
    always_comb begin
        p_ext  = {{(DW-PW){p_r[PW-1]}}, p_r};
        c_ext  = {{(DW-CW){c_r[CW-1]}}, c_r};
        d_full = sub_r ? (p_ext - c_ext) : (p_ext + c_ext);
        d_abs  = d_full[DW-1] ? (~d_full + DW'(1)) : d_full;
        b_ext  = {b_r[BW-1], b_r};
        b_abs  = b_ext[BW] ? (~b_ext + (BW+1)'(1)) : b_ext;
    end

    // One restoring step. The remainder stays below |B| <= 2^(BW-1), so the
    // shifted value fits in BW+1 bits and the result fits back in BW bits.
    always_comb begin
        shifted = {rem, dvd[DW-1]};
        ge      = (shifted >= div_r);
        rem_nxt = ge ? BW'(shifted - div_r) : shifted[BW-1:0];
        dvd_nxt = {dvd[DW-2:0], ge};
    end

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            qout      <= '0;
            rout      <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sub_r <= subadd;
                        p_r   <= pin;
                        c_r   <= cin;
                        b_r   <= bin;
                        state <= PREP;
                    end
                end
                PREP: begin
                    dvd    <= d_abs;
                    div_r  <= b_abs;
                    rem    <= '0;
                    cnt    <= '0;
                    sign_q <= d_full[DW-1] ^ b_r[BW-1];
                    sign_r <= d_full[DW-1];
                    zero_b <= (b_r == '0);
                    state  <= CALC;
                end
                CALC: begin
                    dvd <= dvd_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + CNTW'(1);
                    if (cnt == CNTW'(DW - 1)) begin
                        // The last step's results are folded straight into
                        // the output registers to save a cycle.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        div0      <= zero_b;
                        qout      <= zero_b ? '0 : (sign_q ? (~dvd_nxt + DW'(1)) : dvd_nxt);
                        rout      <= zero_b ? '0 : (sign_r ? (~rem_nxt + BW'(1)) : rem_nxt);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
